// File: rtl/btn_tap_classifier.sv
// rtl/btn_tap_classifier.sv - classifies debounced press pulses into single/double(/triple) tap events
// Optional triple-tap support is enabled by defining TRIPLE_TAP_EN.
module btn_tap_classifier #(
    parameter int TICK_DIV     = 100000,
    parameter int WINDOW_TICKS = 250,
    parameter int EVT_CNT_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 btn_pulse,
    output logic                 single_tap,
    output logic                 double_tap,
    output logic                 triple_tap,
    output logic                 busy,
    output logic [EVT_CNT_W-1:0] evt_count
);

    localparam int PSC_W = $clog2(TICK_DIV);
    localparam int WIN_W = $clog2(WINDOW_TICKS + 1);

    typedef enum logic [1:0] {IDLE, ONE, TWO} state_t;

    state_t             state;
    logic               btn_q;
    logic [PSC_W-1:0]   psc;
    logic [WIN_W-1:0]   win;
    logic               press;
    logic               psc_wrap;
    logic               timeout;
    logic               emit_single;
    logic               emit_double;
    logic               emit_triple;
    logic               emit_any;

    assign press    = btn_pulse & ~btn_q;
    assign psc_wrap = (psc == PSC_W'(TICK_DIV - 1));
    // The wrap that would carry the window counter to WINDOW_TICKS is the expiry edge.
    assign timeout  = psc_wrap && (win == WIN_W'(WINDOW_TICKS - 1));
    assign emit_any = emit_single | emit_double | emit_triple;

    always_comb begin
        emit_single = 1'b0;
        emit_double = 1'b0;
        emit_triple = 1'b0;
        case (state)
            ONE: begin
`ifndef TRIPLE_TAP_EN
                emit_double = press;
`endif
                emit_single = !press && timeout;
            end
`ifdef TRIPLE_TAP_EN
            TWO: begin
                emit_triple = press;
                emit_double = !press && timeout;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            btn_q      <= 1'b0;
            psc        <= '0;
            win        <= '0;
            single_tap <= 1'b0;
            double_tap <= 1'b0;
            triple_tap <= 1'b0;
            busy       <= 1'b0;
            evt_count  <= '0;
        end else begin
            btn_q      <= btn_pulse;
            single_tap <= emit_single;
            double_tap <= emit_double;
            triple_tap <= emit_triple;
            // busy also covers the cycle the event pulse is visible
            busy       <= (state != IDLE) | press;

            if (state == IDLE || press) begin
                psc <= '0;
                win <= '0;
            end else if (psc_wrap) begin
                psc <= '0;
                win <= win + WIN_W'(1);
            end else begin
                psc <= psc + PSC_W'(1);
            end

            if (emit_any && evt_count != {EVT_CNT_W{1'b1}})
                evt_count <= evt_count + EVT_CNT_W'(1);

            case (state)
                IDLE: if (press) state <= ONE;
                ONE: begin
                    if (press) begin
`ifdef TRIPLE_TAP_EN
                        state <= TWO;
`else
                        state <= IDLE;
`endif
                    end else if (timeout) begin
                        state <= IDLE;
                    end
                end
`ifdef TRIPLE_TAP_EN
                TWO: if (press || timeout) state <= IDLE;
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_btn_tap_classifier.sv
// tb/tb_btn_tap_classifier.sv - self-checking bench for btn_tap_classifier (TICK_DIV=4, WINDOW_TICKS=3)
module tb_btn_tap_classifier;

    localparam int TICK_DIV     = 4;
    localparam int WINDOW_TICKS = 3;
    localparam int EVT_CNT_W    = 8;
    localparam int N            = TICK_DIV * WINDOW_TICKS;
    localparam int EVT_MAX      = (1 << EVT_CNT_W) - 1;
    localparam int SCEN_LEN     = 45;
`ifdef TRIPLE_TAP_EN
    localparam int MAX_TAPS     = 3;
`else
    localparam int MAX_TAPS     = 2;
`endif

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 btn_pulse = 1'b0;
    logic                 single_tap;
    logic                 double_tap;
    logic                 triple_tap;
    logic                 busy;
    logic [EVT_CNT_W-1:0] evt_count;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    btn_tap_classifier #(
        .TICK_DIV    (TICK_DIV),
        .WINDOW_TICKS(WINDOW_TICKS),
        .EVT_CNT_W   (EVT_CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_pulse (btn_pulse),
        .single_tap(single_tap),
        .double_tap(double_tap),
        .triple_tap(triple_tap),
        .busy      (busy),
        .evt_count (evt_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Model: count taps and timestamp the latest one; the window expires N cycles after it.
    int   m_cnt = 0;
    int   m_last = 0;
    int   m_evt = 0;
    logic m_prev = 1'b0;
    logic e_single = 1'b0, e_double = 1'b0, e_triple = 1'b0, e_busy = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_cnt    <= 0;
            m_prev   <= 1'b0;
            m_evt    <= 0;
            e_single <= 1'b0;
            e_double <= 1'b0;
            e_triple <= 1'b0;
            e_busy   <= 1'b0;
        end else begin : model_step
            int   cnt;
            int   last;
            int   ev;
            logic p;
            cnt  = m_cnt;
            last = m_last;
            ev   = 0;
            p    = btn_pulse && !m_prev;
            if (cnt > 0 && p) begin
                cnt  = cnt + 1;
                last = cyc;
                if (cnt == MAX_TAPS) begin
                    ev  = cnt;
                    cnt = 0;
                end
            end else if (cnt > 0 && (cyc - last) == N) begin
                ev  = cnt;
                cnt = 0;
            end else if (p) begin
                cnt  = 1;
                last = cyc;
            end
            m_cnt    <= cnt;
            m_last   <= last;
            m_prev   <= btn_pulse;
            e_single <= (ev == 1);
            e_double <= (ev == 2);
            e_triple <= (ev == 3);
            e_busy   <= (cnt > 0) || (ev > 0);
            if (ev > 0 && m_evt < EVT_MAX) m_evt <= m_evt + 1;
        end
    end

    logic [3:0] hist [0:8191];

    always @(negedge clk) begin : compare
        logic [11:0] act;
        logic [11:0] exp_v;
        act   = {single_tap, double_tap, triple_tap, busy, evt_count};
        exp_v = {e_single, e_double, e_triple, e_busy, 8'(m_evt)};
        hist[cyc % 8192] <= {single_tap, double_tap, triple_tap, busy};
        checks = checks + 1;
        if (act !== exp_v) begin
            errors = errors + 1;
            $display("FAIL cycle_compare cyc=%0d actual s/d/t/b/cnt=%b/%b/%b/%b/%0d required %b/%b/%b/%b/%0d",
                     cyc, single_tap, double_tap, triple_tap, busy, evt_count,
                     e_single, e_double, e_triple, e_busy, m_evt);
        end
    end

    task automatic chk(input string name, input int act, input int req);
        checks = checks + 1;
        if (act !== req) begin
            errors = errors + 1;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    int base;
    int n_s, n_d, n_t, t_s, t_d, t_t, b_first, b_last;

    task automatic run_scen(input logic [63:0] bpat, input logic [63:0] rpat);
        @(negedge clk); #1;
        base = cyc;
        for (int i = 0; i < SCEN_LEN; i++) begin
            btn_pulse = bpat[i];
            rst       = !rpat[i];
            @(negedge clk); #1;
        end
        btn_pulse = 1'b0;
        rst       = 1'b1;
        n_s = 0; n_d = 0; n_t = 0;
        t_s = -1; t_d = -1; t_t = -1; b_first = -1; b_last = -1;
        for (int r = 0; r <= SCEN_LEN; r++) begin
            logic [3:0] h;
            h = hist[(base + r) % 8192];
            if (h[3]) begin n_s++; if (t_s < 0) t_s = r; end
            if (h[2]) begin n_d++; if (t_d < 0) t_d = r; end
            if (h[1]) begin n_t++; if (t_t < 0) t_t = r; end
            if (h[0]) begin if (b_first < 0) b_first = r; b_last = r; end
        end
    endtask

    task automatic press_once();
        @(negedge clk); #1;
        btn_pulse = 1'b1;
        @(negedge clk); #1;
        btn_pulse = 1'b0;
        repeat (14) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_single", single_tap, 0);
        chk("reset_double", double_tap, 0);
        chk("reset_triple", triple_tap, 0);
        chk("reset_busy", busy, 0);
        chk("reset_evt_count", evt_count, 0);
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);

        run_scen(64'd1 << 10, 64'h3 << 16);
        chk("rst_abort_events", n_s + n_d + n_t, 0);
        chk("rst_abort_evt_count", evt_count, 0);

        run_scen(64'd1 << 10, 64'd0);
        chk("single_time", t_s, 23);
        chk("single_count", n_s, 1);
        chk("single_busy_first", b_first, 11);
        chk("single_busy_last", b_last, 23);
        chk("single_evt_count", evt_count, 1);

        run_scen((64'd1 << 10) | (64'd1 << 18), 64'd0);
        chk("double_single_none", n_s, 0);
`ifdef TRIPLE_TAP_EN
        chk("double_time", t_d, 31);
        chk("double_busy_last", b_last, 31);
`else
        chk("double_time", t_d, 19);
        chk("double_busy_last", b_last, 19);
`endif

        run_scen((64'd1 << 10) | (64'd1 << 15) | (64'd1 << 20), 64'd0);
`ifdef TRIPLE_TAP_EN
        chk("triple_time", t_t, 21);
        chk("triple_no_single_double", n_s + n_d, 0);
`else
        chk("three_double_time", t_d, 16);
        chk("three_single_time", t_s, 33);
        chk("three_triple_none", n_t, 0);
`endif

        run_scen((64'd1 << 10) | (64'd1 << 22), 64'd0);
        chk("edge_press_no_single", n_s, 0);
`ifdef TRIPLE_TAP_EN
        chk("edge_press_double", t_d, 35);
`else
        chk("edge_press_double", t_d, 23);
`endif

        run_scen(64'h3F << 10, 64'd0);
        chk("held_single_time", t_s, 23);
        chk("held_single_count", n_s, 1);
        chk("held_no_double", n_d, 0);

        @(negedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("sat_reset_evt_count", evt_count, 0);
        #1 rst = 1'b1;
        for (int i = 0; i < 254; i++) press_once();
        chk("sat_254", evt_count, 254);
        press_once();
        chk("sat_255", evt_count, 255);
        press_once();
        chk("sat_hold_256", evt_count, 255);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
